present_round_ctrl: RTL and testbench
=====================================

PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 31, the number of full PRESENT rounds executed per block.
REQ-002 SHALL have ports: inClk  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have ports: inRstN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: inStart  input  1  request to encrypt inData under inKey.
REQ-005 SHALL have ports: inAbort  input  1  cancel the block in progress.
REQ-006 SHALL have ports: inData  input  64  plaintext, sampled only when a start is accepted.
REQ-007 SHALL have ports: inKey  input  80  cipher key, sampled only when a start is accepted.
REQ-008 SHALL have ports: outBusy  output  1  high while a block is in progress.
REQ-009 SHALL have ports: outValid  output  1  one-cycle pulse, outData holds ciphertext.
REQ-010 SHALL have ports: outData  output  64  ciphertext, held until the next outValid.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FINAL.
REQ-012 SHALL accept a start when inStart=1 in IDLE and inAbort=0: load state<=inData, key<=inKey, round<=1, go to RUN.
REQ-013 SHALL, on each RUN edge, set state<=pLayer(sBoxLayer(state XOR key[79:16])), key<=keyUpdate(key, round), round<=round+1.
REQ-014 SHALL use the existing combinational PresentNextStateFun as the single round datapath, with no duplicated S-box or pLayer logic.
REQ-015 SHALL define keyUpdate as: rotate left 61; bits[79:76]<=S(bits[79:76]); bits[19:15]<=bits[19:15] XOR round[4:0].
REQ-016 SHALL leave RUN for FINAL on the edge performing round ROUNDS.
REQ-017 SHALL, in FINAL, register outData<=state XOR key[79:16], drive outValid=1 for exactly one cycle, and return to IDLE.
REQ-018 SHALL give a latency of 32 edges: start sampled at edge 0, outValid high during the cycle after edge 32 (ROUNDS=31).
REQ-019 SHALL drive outBusy=1 in RUN and FINAL and outBusy=0 in IDLE, including the cycle in which outValid=1.
REQ-020 SHALL ignore inStart while outBusy=1, with no queuing and no effect on the block in progress.
REQ-021 SHALL, on inAbort=1 in RUN or FINAL, go to IDLE at the next edge, suppress outValid and leave outData unchanged.
REQ-022 SHALL give inAbort priority when inAbort and inStart are both high in IDLE: no start is accepted.
REQ-023 SHALL accept a start in the cycle outValid is high (back-to-back), with the next outValid exactly 33 cycles after the previous one.
REQ-024 SHALL use a 5-bit round counter with no wrap within one block (values 1..31).

Reset
REQ-025 SHALL, while inRstN=0, asynchronously force FSM=IDLE, outBusy=0, outValid=0, outData=0, state=0, key=0, round=0.
REQ-026 SHALL abandon any block in progress when reset is asserted mid-block, with no outValid after release.
REQ-027 SHALL accept a start on the first rising edge after reset deassertion.

Structure
REQ-028 SHALL place the S-box table, ROUNDS, state/key widths and FSM state encodings in shared package present_pkg.
REQ-029 SHALL implement the key schedule step as sub-module present_key_update (inKey[79:0], inRound[4:0] -> outKey[79:0]), purely combinational.
REQ-030 SHALL keep all registers in present_round_ctrl, with the sub-modules purely combinational.

Verification
REQ-031 SHALL cover: data=0, key=0, start -> outValid exactly 32 cycles later with outData=64'h5579C1387B228445.
REQ-032 SHALL cover: data=0, key=80'hFFFF_FFFFFFFF_FFFFFFFF -> outData=64'hE72C46C0F5945049; data=64'hFFFFFFFFFFFFFFFF, key=0 -> 64'hA112FFC72F68417B.
REQ-033 SHALL cover: data=all ones, key=all ones -> 64'h3333DCD3213210D2, with a second start issued in the outValid cycle -> second outValid 33 cycles later.
REQ-034 SHALL cover: inStart pulsed at cycle 10 of a block with different data -> first result unchanged, no extra outValid.
REQ-035 SHALL cover: inAbort at round 15 -> outBusy low next cycle, no outValid, outData retains the previous ciphertext; a new start then gives the correct vector.
REQ-036 SHALL cover: inRstN asserted asynchronously (between edges) at round 20 -> outputs zero immediately, no outValid after release, correct result on a fresh start.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, controller state encoding and the combinational round function.
package present_pkg;

  localparam int STATE_W        = 64;
  localparam int KEY_W          = 80;
  localparam int ROUND_W        = 5;
  localparam int PRESENT_ROUNDS = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } ctrl_state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays in place.
  function automatic logic [STATE_W-1:0] pLayer(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] y;
    y = '0;
    for (int i = 0; i < STATE_W - 1; i++) begin
      y[(i * 16) % 63] = x[i];
    end
    y[STATE_W-1] = x[STATE_W-1];
    return y;
  endfunction

  function automatic logic [STATE_W-1:0] PresentNextStateFun(input logic [STATE_W-1:0] st,
                                                              input logic [STATE_W-1:0] round_key);
    logic [STATE_W-1:0] mixed;
    logic [STATE_W-1:0] subst;
    mixed = st ^ round_key;
    for (int n = 0; n < STATE_W / 4; n++) begin
      subst[n*4 +: 4] = sbox4(mixed[n*4 +: 4]);
    end
    return pLayer(subst);
  endfunction

endpackage

// File: rtl/present_key_update.sv
// One step of the PRESENT-80 key schedule, purely combinational.
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0]   inKey,
  input  logic [ROUND_W-1:0] inRound,
  output logic [KEY_W-1:0]   outKey
);

  logic [KEY_W-1:0] rotated;

  // Rotating left by 61 is the same as rotating right by 19.
  always_comb begin
    rotated        = {inKey[18:0], inKey[79:19]};
    outKey         = rotated;
    outKey[79:76]  = sbox4(rotated[79:76]);
    outKey[19:15]  = rotated[19:15] ^ inRound;
  end

endmodule

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 encryptor: one round per clock, start/abort handshake, one-cycle result pulse.
module present_round_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS
) (
  input  logic               inClk,
  input  logic               inRstN,
  input  logic               inStart,
  input  logic               inAbort,
  input  logic [STATE_W-1:0] inData,
  input  logic [KEY_W-1:0]   inKey,
  output logic               outBusy,
  output logic               outValid,
  output logic [STATE_W-1:0] outData
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);

  ctrl_state_e        fsm, fsm_next;
  logic [STATE_W-1:0] state;
  logic [KEY_W-1:0]   key;
  logic [KEY_W-1:0]   key_next;
  logic [ROUND_W-1:0] round;
  logic               load;
  logic               step;
  logic               emit;

  present_key_update u_key_update (
    .inKey   (key),
    .inRound (round),
    .outKey  (key_next)
  );

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) fsm <= IDLE;
    else         fsm <= fsm_next;
  end

  // Abort wins over everything, including a start in IDLE and the result write in FINAL.
  always_comb begin
    fsm_next = fsm;
    load     = 1'b0;
    step     = 1'b0;
    emit     = 1'b0;
    outBusy  = (fsm != IDLE);
    case (fsm)
      IDLE: begin
        if (inStart && !inAbort) begin
          load     = 1'b1;
          fsm_next = RUN;
        end
      end
      RUN: begin
        if (inAbort) begin
          fsm_next = IDLE;
        end else begin
          step = 1'b1;
          if (round == LAST_ROUND) fsm_next = FINAL;
        end
      end
      FINAL: begin
        fsm_next = IDLE;
        emit     = !inAbort;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state    <= '0;
      key      <= '0;
      round    <= '0;
      outValid <= 1'b0;
      outData  <= '0;
    end else begin
      outValid <= emit;
      if (load) begin
        state <= inData;
        key   <= inKey;
        round <= ROUND_W'(1);
      end else if (step) begin
        state <= PresentNextStateFun(state, key[79:16]);
        key   <= key_next;
        round <= (round == LAST_ROUND) ? round : round + ROUND_W'(1);
      end
      if (emit) outData <= state ^ key[79:16];
    end
  end

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: known PRESENT-80 vectors plus random blocks against a reference cipher.
module tb_present_round_ctrl;

  logic        inClk = 1'b0;
  logic        inRstN = 1'b0;
  logic        inStart = 1'b0;
  logic        inAbort = 1'b0;
  logic [63:0] inData = '0;
  logic [79:0] inKey = '0;
  logic        outBusy;
  logic        outValid;
  logic [63:0] outData;

  int total = 0;
  int bad = 0;

  present_round_ctrl #(.ROUNDS(31)) dut (
    .inClk    (inClk),
    .inRstN   (inRstN),
    .inStart  (inStart),
    .inAbort  (inAbort),
    .inData   (inData),
    .inKey    (inKey),
    .outBusy  (outBusy),
    .outValid (outValid),
    .outData  (outData)
  );

  always #5 inClk = ~inClk;

  // Reference cipher written straight from the algorithm description.
  function automatic logic [63:0] presentRef(input logic [63:0] d, input logic [79:0] k);
    logic [3:0]  sb [16];
    logic [63:0] s, t;
    logic [79:0] kk;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    s  = d;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) t[n*4 +: 4] = sb[s[n*4 +: 4]];
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (i * 16) % 63] = t[i];
      kk = (kk << 61) | (kk >> 19);
      kk[79:76] = sb[kk[79:76]];
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic randomKey(output logic [79:0] k);
    k = {16'($urandom), $urandom, $urandom};
  endtask

  // Presents a start for one edge, then scrambles the inputs to catch late sampling.
  task automatic applyStimulus(input logic [63:0] d, input logic [79:0] k);
    logic [79:0] junk;
    inData  = d;
    inKey   = k;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    randomKey(junk);
    inKey  = junk;
    inData = {$urandom, $urandom};
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!outValid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic countValids(input int cycles, output int nv);
    nv = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (outValid) nv++;
    end
  endtask

  // Full block: start, latency, result, busy low with valid, single-cycle pulse.
  task automatic runBlock(input string tag, input logic [63:0] d, input logic [79:0] k,
                          input logic [63:0] expected);
    int n;
    applyStimulus(d, k);
    waitValid(n);
    checkOutput({tag, " latency"}, 64'(n), 64'd32);
    checkOutput({tag, " data"}, outData, expected);
    checkOutput({tag, " busy at valid"}, 64'(outBusy), 64'd0);
    tick();
    checkOutput({tag, " valid pulse"}, 64'(outValid), 64'd0);
    checkOutput({tag, " data held"}, outData, expected);
  endtask

  initial begin
    int          n;
    int          nv;
    logic [63:0] d, d2, prev;
    logic [79:0] k, k2;

    #12;
    checkOutput("reset busy", 64'(outBusy), 64'd0);
    checkOutput("reset valid", 64'(outValid), 64'd0);
    checkOutput("reset data", outData, 64'd0);
    #11 inRstN = 1'b1;

    runBlock("zero/zero", 64'd0, 80'd0, 64'h5579C1387B228445);
    runBlock("zero/ones", 64'd0, {80{1'b1}}, 64'hE72C46C0F5945049);
    runBlock("ones/zero", {64{1'b1}}, 80'd0, 64'hA112FFC72F68417B);

    // Back-to-back: second start issued in the outValid cycle.
    applyStimulus({64{1'b1}}, {80{1'b1}});
    waitValid(n);
    checkOutput("ones/ones data", outData, 64'h3333DCD3213210D2);
    d = {$urandom, $urandom};
    randomKey(k);
    applyStimulus(d, k);
    waitValid(n);
    checkOutput("b2b gap", 64'(n + 1), 64'd33);
    checkOutput("b2b data", outData, presentRef(d, k));
    tick();

    // Start while busy must be ignored.
    d = {$urandom, $urandom};
    randomKey(k);
    applyStimulus(d, k);
    repeat (9) tick();
    inData  = ~d;
    inKey   = ~k;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    waitValid(n);
    checkOutput("busy start latency", 64'(n + 10), 64'd32);
    checkOutput("busy start data", outData, presentRef(d, k));
    countValids(40, nv);
    checkOutput("busy start extra valid", 64'(nv), 64'd0);

    // Abort at round 15.
    prev = outData;
    d = {$urandom, $urandom};
    randomKey(k);
    applyStimulus(d, k);
    repeat (14) tick();
    inAbort = 1'b1;
    tick();
    inAbort = 1'b0;
    checkOutput("abort busy", 64'(outBusy), 64'd0);
    countValids(40, nv);
    checkOutput("abort no valid", 64'(nv), 64'd0);
    checkOutput("abort data kept", outData, prev);
    runBlock("after abort", 64'd0, 80'd0, 64'h5579C1387B228445);

    // Abort has priority over start in IDLE.
    inStart = 1'b1;
    inAbort = 1'b1;
    tick();
    inStart = 1'b0;
    inAbort = 1'b0;
    checkOutput("abort priority busy", 64'(outBusy), 64'd0);
    countValids(40, nv);
    checkOutput("abort priority valid", 64'(nv), 64'd0);

    // Asynchronous reset mid-block at round 20.
    d = {$urandom, $urandom};
    randomKey(k);
    applyStimulus(d, k);
    repeat (19) tick();
    #2 inRstN = 1'b0;
    #1;
    checkOutput("async rst busy", 64'(outBusy), 64'd0);
    checkOutput("async rst valid", 64'(outValid), 64'd0);
    checkOutput("async rst data", outData, 64'd0);
    tick();
    tick();
    #2 inRstN = 1'b1;
    countValids(40, nv);
    checkOutput("post rst no valid", 64'(nv), 64'd0);
    d2 = {$urandom, $urandom};
    randomKey(k2);
    runBlock("post rst", d2, k2, presentRef(d2, k2));

    for (int b = 0; b < 6; b++) begin
      d = {$urandom, $urandom};
      randomKey(k);
      runBlock("random", d, k, presentRef(d, k));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
